// File: rtl/noc_flit_credit_rx_if.sv
// rtl/noc_flit_credit_rx_if.sv - valid/ready flit stream delivered by the credit receiver
interface noc_flit_credit_rx_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEST_WIDTH = 6
);
    logic                  out_valid;
    logic                  out_ready;
    logic [FLIT_WIDTH-1:0] out_data;
    logic [DEST_WIDTH-1:0] out_dest;
    logic                  out_last;

    // Producer side: the receiver presenting its FIFO head.
    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_dest,
        output out_last
    );

    // Consumer side: whatever drains the flits.
    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_dest,
        input  out_last
    );
endinterface

// File: rtl/noc_flit_credit_rx.sv
// rtl/noc_flit_credit_rx.sv - credit-based link receiver with flit FIFO, framing and overflow checks
module noc_flit_credit_rx #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    noc_flit_credit_rx_if.master  stream,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  overflow_err,
    output logic                  framing_err
);
    localparam int PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int OCC_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_IN_PKT
    } state_t;

    logic [FLIT_WIDTH-1:0] data_mem [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] dest_mem [FLIT_BUFFER_DEPTH];
    logic                  last_mem [FLIT_BUFFER_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    state_t                state_q;
    state_t                state_d;
    logic [DEST_WIDTH-1:0] pkt_dest_q;
    logic [DEST_WIDTH-1:0] pkt_dest_d;
    logic                  dest_mismatch;

    assign full  = (occ == FULL_OCC);
    assign empty = (occ == '0);
    assign pop   = stream.out_valid & stream.out_ready;
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign push  = send_in & (~full | pop);
    assign drop  = send_in & full & ~pop;

    // Head is presented combinationally so a new flit is visible one cycle after its push.
    assign stream.out_valid = ~empty;
    assign stream.out_data  = data_mem[rd_ptr];
    assign stream.out_dest  = dest_mem[rd_ptr];
    assign stream.out_last  = last_mem[rd_ptr];

    // Flit storage write; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_noc) begin
        if (push) begin
            data_mem[wr_ptr] <= data_in;
            dest_mem[wr_ptr] <= dest_in;
            last_mem[wr_ptr] <= is_tail_in;
        end
    end

    // Pointers wrap explicitly so non-power-of-2 depths work.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // One registered credit per popped flit; reset discards any pending credit.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            credit_out <= 1'b0;
        end else begin
            credit_out <= pop;
        end
    end

    // Delivered packet counter, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            pkt_count <= '0;
        end else if (pop & stream.out_last) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

    // Framing FSM state register.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q    <= S_IDLE;
            pkt_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            pkt_dest_q <= pkt_dest_d;
        end
    end

    // Framing FSM next state; only accepted pushes advance it, dropped flits are ignored.
    always_comb begin
        state_d       = state_q;
        pkt_dest_d    = pkt_dest_q;
        dest_mismatch = 1'b0;
        if (push) begin
            case (state_q)
                S_IDLE: begin
                    pkt_dest_d = dest_in;
                    if (!is_tail_in) begin
                        state_d = S_IN_PKT;
                    end
                end
                S_IN_PKT: begin
                    if (dest_in != pkt_dest_q) begin
                        dest_mismatch = 1'b1;
                    end
                    if (is_tail_in) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            overflow_err <= 1'b0;
            framing_err  <= 1'b0;
        end else begin
            if (drop) begin
                overflow_err <= 1'b1;
            end
            if (dest_mismatch) begin
                framing_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_noc_flit_credit_rx.sv
// tb/tb_noc_flit_credit_rx.sv - directed self-checking bench for noc_flit_credit_rx
module tb_noc_flit_credit_rx;
    logic        clk_noc = 1'b0;
    logic        rst_noc_sync;
    logic [31:0] data_in;
    logic [5:0]  dest_in;
    logic        is_tail_in;
    logic        send_in;
    logic        credit_out;
    logic [15:0] pkt_count;
    logic        overflow_err;
    logic        framing_err;

    int checks = 0;
    int errors = 0;

    noc_flit_credit_rx_if #(.FLIT_WIDTH(32), .DEST_WIDTH(6)) s ();

    noc_flit_credit_rx #(
        .FLIT_WIDTH(32),
        .DEST_WIDTH(6),
        .FLIT_BUFFER_DEPTH(2),
        .CNT_WIDTH(16)
    ) dut (
        .clk_noc(clk_noc),
        .rst_noc_sync(rst_noc_sync),
        .data_in(data_in),
        .dest_in(dest_in),
        .is_tail_in(is_tail_in),
        .send_in(send_in),
        .credit_out(credit_out),
        .stream(s),
        .pkt_count(pkt_count),
        .overflow_err(overflow_err),
        .framing_err(framing_err)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] ds, input logic t);
        send_in    = 1'b1;
        data_in    = d;
        dest_in    = ds;
        is_tail_in = t;
    endtask

    task automatic idle_in();
        send_in    = 1'b0;
        data_in    = '0;
        dest_in    = '0;
        is_tail_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_noc_sync = 1'b1;
        idle_in();
        s.out_ready = 1'b0;
        tick();
        rst_noc_sync = 1'b0;
    endtask

    initial begin
        rst_noc_sync = 1'b1;
        idle_in();
        s.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(s.out_valid), 32'd0);
        chk("rst_credit", 32'(credit_out), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        chk("rst_frm", 32'(framing_err), 32'd0);
        rst_noc_sync = 1'b0;

        // A (tail) then B held with out_ready low, then drained over two cycles
        send(32'hAAAA_0001, 6'h01, 1'b1);
        tick();
        chk("t1_valid_a", 32'(s.out_valid), 32'd1);
        chk("t1_data_a", s.out_data, 32'hAAAA_0001);
        send(32'hBBBB_0002, 6'h02, 1'b0);
        tick();
        idle_in();
        chk("t1_hold_data", s.out_data, 32'hAAAA_0001);
        chk("t1_hold_last", 32'(s.out_last), 32'd1);
        chk("t1_no_credit", 32'(credit_out), 32'd0);
        s.out_ready = 1'b1;
        tick();
        chk("t1_credit1", 32'(credit_out), 32'd1);
        chk("t1_data_b", s.out_data, 32'hBBBB_0002);
        chk("t1_pkt1", 32'(pkt_count), 32'd1);
        tick();
        chk("t1_credit2", 32'(credit_out), 32'd1);
        chk("t1_empty", 32'(s.out_valid), 32'd0);
        chk("t1_pkt_still1", 32'(pkt_count), 32'd1);
        s.out_ready = 1'b0;
        tick();
        chk("t1_credit_end", 32'(credit_out), 32'd0);

        // 3-flit packet to dest 0x05 streamed with out_ready high
        do_reset();
        s.out_ready = 1'b1;
        send(32'h5000_0001, 6'h05, 1'b0);
        tick();
        chk("t2_h_data", s.out_data, 32'h5000_0001);
        chk("t2_h_credit", 32'(credit_out), 32'd0);
        send(32'h5000_0002, 6'h05, 1'b0);
        tick();
        chk("t2_b_data", s.out_data, 32'h5000_0002);
        chk("t2_b_credit", 32'(credit_out), 32'd1);
        send(32'h5000_0003, 6'h05, 1'b1);
        tick();
        idle_in();
        chk("t2_t_data", s.out_data, 32'h5000_0003);
        chk("t2_t_last", 32'(s.out_last), 32'd1);
        chk("t2_t_credit", 32'(credit_out), 32'd1);
        tick();
        chk("t2_c3", 32'(credit_out), 32'd1);
        chk("t2_pkt", 32'(pkt_count), 32'd1);
        chk("t2_empty", 32'(s.out_valid), 32'd0);
        tick();
        chk("t2_c_end", 32'(credit_out), 32'd0);
        chk("t2_frm", 32'(framing_err), 32'd0);
        chk("t2_ovf", 32'(overflow_err), 32'd0);

        // Overflow: third flit into a full FIFO is dropped
        do_reset();
        send(32'hF000_0001, 6'h01, 1'b1);
        tick();
        send(32'hF000_0002, 6'h01, 1'b1);
        tick();
        chk("t3_ovf_before", 32'(overflow_err), 32'd0);
        send(32'hDEAD_BEEF, 6'h01, 1'b1);
        tick();
        idle_in();
        chk("t3_ovf_set", 32'(overflow_err), 32'd1);
        s.out_ready = 1'b1;
        tick();
        chk("t3_second", s.out_data, 32'hF000_0002);
        tick();
        chk("t3_drained", 32'(s.out_valid), 32'd0);
        chk("t3_pkt", 32'(pkt_count), 32'd2);
        chk("t3_ovf_sticky", 32'(overflow_err), 32'd1);

        // Full FIFO with simultaneous push and pop: slot reused, no overflow
        do_reset();
        send(32'h6000_0001, 6'h04, 1'b1);
        tick();
        send(32'h6000_0002, 6'h04, 1'b1);
        tick();
        send(32'h6000_0003, 6'h04, 1'b1);
        s.out_ready = 1'b1;
        tick();
        idle_in();
        chk("t4_no_ovf", 32'(overflow_err), 32'd0);
        chk("t4_head2", s.out_data, 32'h6000_0002);
        tick();
        chk("t4_head3", s.out_data, 32'h6000_0003);
        chk("t4_valid3", 32'(s.out_valid), 32'd1);
        tick();
        chk("t4_empty", 32'(s.out_valid), 32'd0);
        chk("t4_pkt", 32'(pkt_count), 32'd3);

        // Framing: body dest differs from head dest
        do_reset();
        send(32'h3000_0001, 6'h03, 1'b0);
        tick();
        chk("t5_frm_head", 32'(framing_err), 32'd0);
        send(32'h7000_0002, 6'h07, 1'b1);
        tick();
        idle_in();
        chk("t5_frm_set", 32'(framing_err), 32'd1);
        s.out_ready = 1'b1;
        tick();
        chk("t5_body_data", s.out_data, 32'h7000_0002);
        chk("t5_body_dest", 32'(s.out_dest), 32'h07);
        chk("t5_body_last", 32'(s.out_last), 32'd1);
        tick();
        chk("t5_pkt", 32'(pkt_count), 32'd1);
        s.out_ready = 1'b0;

        // Mid-packet reset with 2 flits buffered and both errors raised
        send(32'h9000_0001, 6'h01, 1'b0);
        tick();
        send(32'h9000_0002, 6'h01, 1'b0);
        tick();
        send(32'h9000_0003, 6'h01, 1'b0);
        tick();
        idle_in();
        chk("t6_ovf_pre", 32'(overflow_err), 32'd1);
        rst_noc_sync = 1'b1;
        s.out_ready = 1'b1;
        tick();
        chk("t6_valid", 32'(s.out_valid), 32'd0);
        chk("t6_ovf", 32'(overflow_err), 32'd0);
        chk("t6_frm", 32'(framing_err), 32'd0);
        chk("t6_pkt", 32'(pkt_count), 32'd0);
        chk("t6_credit", 32'(credit_out), 32'd0);
        rst_noc_sync = 1'b0;
        tick();
        chk("t6_credit_after", 32'(credit_out), 32'd0);
        chk("t6_valid_after", 32'(s.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
